// File: rtl/cmd_pkg.sv
// Shared definitions for the DDR command queue: command encodings, default
// field widths and the packed entry width helper.
package cmd_pkg;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam int ADDR_W_DEF  = 27;
    localparam int BURST_W_DEF = 6;
    localparam int DATA_W_DEF  = 128;

    // Entry layout, MSB first: {cmd_type, addr, burst_cnt, wt_data, wt_mask}.
    function automatic int cmd_width(input int addr_w, input int burst_w, input int data_w);
        return 1 + addr_w + burst_w + data_w + data_w / 8;
    endfunction

    localparam int CMD_W = cmd_width(ADDR_W_DEF, BURST_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for the command queue: one synchronous write port
// and one asynchronous read port, intended to map onto LUT RAM.
module sync_fifo_mem
    import cmd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = CMD_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointers, and a
    // reset term here would stop the array mapping onto LUT RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cmd_fifo_sync.sv
// Single-clock first-word-fall-through command queue in front of the DDR
// controller command port, with registered status, occupancy and flush.
module cmd_fifo_sync
    import cmd_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BURST_W  = BURST_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2,
    localparam int MASK_W  = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,

    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic                     push_cmd_type,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [BURST_W-1:0]       push_burst_cnt,
    input  logic [DATA_W-1:0]        push_wt_data,
    input  logic [MASK_W-1:0]        push_wt_mask,

    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic                     pop_cmd_type,
    output logic [ADDR_W-1:0]        pop_addr,
    output logic [BURST_W-1:0]       pop_burst_cnt,
    output logic [DATA_W-1:0]        pop_wt_data,
    output logic [MASK_W-1:0]        pop_wt_mask,

    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PTR_W   = IDX_W + 1;
    localparam int ENTRY_W = cmd_width(ADDR_W, BURST_W, DATA_W);

    localparam logic [PTR_W-1:0] FULL_LVL  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_TH);

    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W-1:0]   wr_ptr_next, rd_ptr_next, level_next;
    logic               push_fire, pop_fire, mem_wr_en;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    assign push_fire = push_valid & push_ready;
    assign pop_fire  = pop_valid & pop_ready;
    // A push landing in a flush (or reset) cycle is dropped along with the rest.
    assign mem_wr_en = push_fire & ~flush & rstn;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        level_next  = level;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (push_fire) wr_ptr_next = wr_ptr + PTR_W'(1);
            if (pop_fire)  rd_ptr_next = rd_ptr + PTR_W'(1);
            level_next = level + PTR_W'(push_fire) - PTR_W'(pop_fire);
        end
    end

    // Status flags are registered from level_next, so neither handshake input
    // has a combinational path to the opposite side's flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            push_ready  <= 1'b0;
            pop_valid   <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values regardless of statement order.
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            level       <= level_next;
            push_ready  <= (level_next != FULL_LVL);
            pop_valid   <= (level_next != '0);
            almost_full <= (level_next >= AFULL_LVL);
        end
    end

    assign wr_entry = {push_cmd_type, push_addr, push_burst_cnt, push_wt_data, push_wt_mask};

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr[IDX_W-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[IDX_W-1:0]),
        .rd_data (rd_entry)
    );

    assign {pop_cmd_type, pop_addr, pop_burst_cnt, pop_wt_data, pop_wt_mask} = rd_entry;

endmodule

// File: tb/tb_cmd_fifo_sync.sv
// Directed bench for cmd_fifo_sync (DEPTH=4, AFULL_TH=3): stimulus pushes the
// expected entries into a scoreboard queue, a monitor pops and compares them.
module tb_cmd_fifo_sync;
    import cmd_pkg::*;

    localparam int ADDR_W  = 27;
    localparam int BURST_W = 6;
    localparam int DATA_W  = 128;
    localparam int MASK_W  = DATA_W / 8;
    localparam int DEPTH   = 4;

    typedef struct packed {
        logic               cmd_type;
        logic [ADDR_W-1:0]  addr;
        logic [BURST_W-1:0] burst_cnt;
        logic [DATA_W-1:0]  wt_data;
        logic [MASK_W-1:0]  wt_mask;
    } entry_t;

    logic                   clk;
    logic                   rstn;
    logic                   flush;
    logic                   push_valid;
    logic                   push_ready;
    logic                   push_cmd_type;
    logic [ADDR_W-1:0]      push_addr;
    logic [BURST_W-1:0]     push_burst_cnt;
    logic [DATA_W-1:0]      push_wt_data;
    logic [MASK_W-1:0]      push_wt_mask;
    logic                   pop_valid;
    logic                   pop_ready;
    logic                   pop_cmd_type;
    logic [ADDR_W-1:0]      pop_addr;
    logic [BURST_W-1:0]     pop_burst_cnt;
    logic [DATA_W-1:0]      pop_wt_data;
    logic [MASK_W-1:0]      pop_wt_mask;
    logic [$clog2(DEPTH):0] level;
    logic                   almost_full;

    entry_t exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;

    cmd_fifo_sync #(
        .ADDR_W   (ADDR_W),
        .BURST_W  (BURST_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (3)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .push_cmd_type  (push_cmd_type),
        .push_addr      (push_addr),
        .push_burst_cnt (push_burst_cnt),
        .push_wt_data   (push_wt_data),
        .push_wt_mask   (push_wt_mask),
        .pop_valid      (pop_valid),
        .pop_ready      (pop_ready),
        .pop_cmd_type   (pop_cmd_type),
        .pop_addr       (pop_addr),
        .pop_burst_cnt  (pop_burst_cnt),
        .pop_wt_data    (pop_wt_data),
        .pop_wt_mask    (pop_wt_mask),
        .level          (level),
        .almost_full    (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Advance one clock; inputs change and status is sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic entry_t mk(input logic t, input int a, input int b,
                                  input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        entry_t e;
        e.cmd_type  = t;
        e.addr      = ADDR_W'(a);
        e.burst_cnt = BURST_W'(b);
        e.wt_data   = d;
        e.wt_mask   = m;
        return e;
    endfunction

    task automatic drive(input entry_t e);
        push_cmd_type  = e.cmd_type;
        push_addr      = e.addr;
        push_burst_cnt = e.burst_cnt;
        push_wt_data   = e.wt_data;
        push_wt_mask   = e.wt_mask;
    endtask

    // Monitor: at the falling edge, a pop that will fire on the next rising
    // edge is compared against the head of the scoreboard.
    always @(negedge clk) begin
        entry_t want;
        entry_t got;
        if (rstn === 1'b1 && flush === 1'b0 && pop_valid === 1'b1 && pop_ready === 1'b1) begin
            n_vec++;
            got = {pop_cmd_type, pop_addr, pop_burst_cnt, pop_wt_data, pop_wt_mask};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got addr %0h, expected no entry", pop_addr);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL pop_entry: got %h, expected %h", got, want);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        entry_t e;
        rstn       = 1'b0;
        flush      = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        drive(mk(CMD_RD, 0, 0, '0, '0));

        // Reset release
        repeat (3) cyc();
        check("rst_push_ready", push_ready, 0);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_level", level, 0);
        check("rst_almost_full", almost_full, 0);
        rstn = 1'b1;
        check("release_push_ready_low", push_ready, 0);
        cyc();
        check("release_push_ready_high", push_ready, 1);
        check("release_pop_valid", pop_valid, 0);
        check("release_level", level, 0);

        // Single write command
        e = mk(CMD_WR, 'h123_4567, 8, {16{8'hA5}}, 16'hFFFF);
        drive(e);
        push_valid = 1'b1;
        exp_q.push_back(e);
        cyc();
        push_valid = 1'b0;
        check("single_pop_valid", pop_valid, 1);
        check("single_level", level, 1);
        pop_ready = 1'b1;
        cyc();
        pop_ready = 1'b0;
        check("single_level_after_pop", level, 0);
        check("single_pop_valid_after_pop", pop_valid, 0);

        // Fill to full with pop_ready low
        for (int i = 0; i < 4; i++) begin
            e = mk(i[0], i, i + 1, {4{32'hC0DE_0000 | 32'(i)}}, 16'h00F0 ^ 16'(i));
            drive(e);
            push_valid = 1'b1;
            exp_q.push_back(e);
            cyc();
            check("fill_level", level, 64'(i + 1));
            check("fill_almost_full", almost_full, 64'(i + 1 >= 3));
            check("fill_push_ready", push_ready, 64'(i + 1 != 4));
        end
        drive(mk(CMD_WR, 'h99, 1, '1, '1));
        repeat (2) begin
            cyc();
            check("full_holdoff_push_ready", push_ready, 0);
            check("full_holdoff_level", level, 4);
        end

        // Simultaneous push and pop at full: only the pop fires
        pop_ready = 1'b1;
        cyc();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        check("full_pushpop_level", level, 3);
        check("full_pushpop_push_ready", push_ready, 1);
        check("full_pushpop_almost_full", almost_full, 1);

        // Drain the remaining entries
        pop_ready = 1'b1;
        repeat (3) cyc();
        pop_ready = 1'b0;
        check("drain_level", level, 0);
        check("drain_pop_valid", pop_valid, 0);
        check("drain_almost_full", almost_full, 0);

        // Streaming across pointer wraps
        push_valid = 1'b1;
        pop_ready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            e = mk(i[1], i, 63 - i, {4{32'h5A00_0000 + 32'(i)}}, 16'hFFFF ^ 16'(i));
            drive(e);
            exp_q.push_back(e);
            cyc();
            check("stream_level", level, 1);
            check("stream_push_ready", push_ready, 1);
        end
        push_valid = 1'b0;
        cyc();
        pop_ready = 1'b0;
        check("stream_level_end", level, 0);

        // Flush at level 3 concurrent with a push
        for (int i = 0; i < 3; i++) begin
            e = mk(CMD_RD, 'h40 + i, 2, {8{16'hBEE0 + 16'(i)}}, 16'h0F0F);
            drive(e);
            push_valid = 1'b1;
            exp_q.push_back(e);
            cyc();
        end
        check("preflush_level", level, 3);
        check("preflush_almost_full", almost_full, 1);
        drive(mk(CMD_WR, 'h50, 3, {16{8'h50}}, 16'h5555));
        flush = 1'b1;
        exp_q.delete();
        cyc();
        flush      = 1'b0;
        push_valid = 1'b0;
        check("flush_level", level, 0);
        check("flush_pop_valid", pop_valid, 0);
        check("flush_push_ready", push_ready, 1);
        check("flush_almost_full", almost_full, 0);
        e = mk(CMD_WR, 'h60, 4, {16{8'h60}}, 16'hAAAA);
        drive(e);
        push_valid = 1'b1;
        exp_q.push_back(e);
        cyc();
        push_valid = 1'b0;
        check("postflush_level", level, 1);
        pop_ready = 1'b1;
        cyc();
        pop_ready = 1'b0;
        check("postflush_level_after_pop", level, 0);

        // Reset in the middle of operation
        for (int i = 0; i < 2; i++) begin
            e = mk(CMD_RD, 'h70 + i, 5, {16{8'h70}}, 16'h1234);
            drive(e);
            push_valid = 1'b1;
            exp_q.push_back(e);
            cyc();
        end
        push_valid = 1'b0;
        rstn = 1'b0;
        exp_q.delete();
        cyc();
        check("midrst_level", level, 0);
        check("midrst_push_ready", push_ready, 0);
        check("midrst_pop_valid", pop_valid, 0);
        rstn = 1'b1;
        check("midrst_release_push_ready_low", push_ready, 0);
        cyc();
        check("midrst_release_push_ready_high", push_ready, 1);
        e = mk(CMD_WR, 'h80, 9, {16{8'h80}}, 16'h8001);
        drive(e);
        push_valid = 1'b1;
        exp_q.push_back(e);
        cyc();
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        cyc();
        pop_ready = 1'b0;
        check("midrst_final_level", level, 0);

        repeat (2) cyc();
        check("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
